// File: rtl/hazard_pkg.sv
// hazard_pkg: shared widths, default mult/div latencies and the control-mode encoding
// used by hazard_ctrl and md_timer.
package hazard_pkg;

  localparam int unsigned REG_W             = 5;
  localparam int unsigned MD_CNT_W          = 8;
  localparam int unsigned MD_MUL_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF = 10;

  typedef enum logic [1:0] {
    CtrlNormal,
    CtrlStall,
    CtrlRedirect,
    CtrlReset
  } ctrl_mode_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_flush;
    logic id_ex_flush;
  } ctrl_t;

  // Map a control mode onto the four pipeline control outputs.
  function automatic ctrl_t mode_to_ctrl(ctrl_mode_e mode);
    ctrl_t c;
    unique case (mode)
      CtrlNormal:   c = '{pc_write: 1'b1, if_id_write: 1'b1, if_flush: 1'b0, id_ex_flush: 1'b0};
      CtrlStall:    c = '{pc_write: 1'b0, if_id_write: 1'b0, if_flush: 1'b0, id_ex_flush: 1'b1};
      CtrlRedirect: c = '{pc_write: 1'b1, if_id_write: 1'b0, if_flush: 1'b1, id_ex_flush: 1'b0};
      default:      c = '{pc_write: 1'b0, if_id_write: 1'b0, if_flush: 1'b1, id_ex_flush: 1'b1};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/md_timer.sv
// md_timer: loadable down-counter tracking mult/div unit occupancy. A new start always
// reloads, even while a previous operation is still counting down.
module md_timer
  import hazard_pkg::*;
#(
  parameter int unsigned MulCycles = MD_MUL_CYCLES_DEF,
  parameter int unsigned DivCycles = MD_DIV_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                is_div_i,
  output logic [MD_CNT_W-1:0] cnt_o,
  output logic                busy_o
);

  localparam logic [MD_CNT_W-1:0] MulLoad = MD_CNT_W'(MulCycles);
  localparam logic [MD_CNT_W-1:0] DivLoad = MD_CNT_W'(DivCycles);

  logic [MD_CNT_W-1:0] cnt_d, cnt_q;

  // Next count: reload on start, otherwise decrement and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = is_div_i ? DivLoad : MulLoad;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register; reset aborts any occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage MIPS core. Detects load-use
// hazards, branch/jump redirects and mult/div occupancy, and drives PC / IF/ID / ID/EX
// controls plus a saturating stall-cycle counter.
// Mult/div tracking is compiled in only when HAZARD_MD_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MD_MUL_CYCLES = MD_MUL_CYCLES_DEF,
  parameter int unsigned MD_DIV_CYCLES = MD_DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             md_start,
  input  logic             md_is_div,
  input  logic             id_md_read,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_flush,
  output logic             id_ex_flush,
  output logic             md_busy,
  output logic [15:0]      stall_count
);

  logic       lu;
  logic       mdh;
  logic       stall;
  logic       redirect;
  ctrl_mode_e mode;
  ctrl_t      ctrl;

  logic [15:0] stall_count_d, stall_count_q;

`ifdef HAZARD_MD_EN
  logic [MD_CNT_W-1:0] md_cnt;

  md_timer #(
    .MulCycles(MD_MUL_CYCLES),
    .DivCycles(MD_DIV_CYCLES)
  ) u_md_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (md_start),
    .is_div_i(md_is_div),
    .cnt_o   (md_cnt),
    .busy_o  (md_busy)
  );

  // HI/LO readers wait from the start cycle until the counter reads zero.
  assign mdh = id_md_read && (md_start || (md_cnt != '0));
`else
  logic unused_md;
  assign unused_md = ^{md_start, md_is_div, id_md_read, 8'(MD_MUL_CYCLES), 8'(MD_DIV_CYCLES)};
  assign mdh       = 1'b0;
  assign md_busy   = 1'b0;
`endif

  // Hazard detection; a stall wins over a redirect because branch operands are not valid yet.
  always_comb begin
    lu       = ex_memread && (ex_rt != '0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    stall    = lu || mdh;
    redirect = (branch_taken || jump) && !stall;
  end

  // Mode selection and decode to the control outputs; reset forces the safe pattern.
  always_comb begin
    mode = CtrlNormal;
    if (!rst_n) begin
      mode = CtrlReset;
    end else if (stall) begin
      mode = CtrlStall;
    end else if (redirect) begin
      mode = CtrlRedirect;
    end
    ctrl        = mode_to_ctrl(mode);
    pc_write    = ctrl.pc_write;
    if_id_write = ctrl.if_id_write;
    if_flush    = ctrl.if_flush;
    id_ex_flush = ctrl.id_ex_flush;
  end

  // Saturating stall-cycle counter next state.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl. Mult/div timing checks are
// exercised when HAZARD_MD_EN is defined; otherwise the bench checks those inputs are ignored.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_memread, branch_taken, jump;
  logic        md_start, md_is_div, id_md_read;
  logic        pc_write, if_id_write, if_flush, id_ex_flush, md_busy;
  logic [15:0] stall_count;
  logic [3:0]  ctrl;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_sc = '0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_memread  (ex_memread),
    .ex_rt       (ex_rt),
    .branch_taken(branch_taken),
    .jump        (jump),
    .md_start    (md_start),
    .md_is_div   (md_is_div),
    .id_md_read  (id_md_read),
    .pc_write    (pc_write),
    .if_id_write (if_id_write),
    .if_flush    (if_flush),
    .id_ex_flush (id_ex_flush),
    .md_busy     (md_busy),
    .stall_count (stall_count)
  );

  // {pc_write, if_id_write, if_flush, id_ex_flush}
  assign ctrl = {pc_write, if_id_write, if_flush, id_ex_flush};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; the caller states whether that edge is a stall edge.
  task automatic tick(input bit st);
    if (st && exp_sc != 16'hFFFF) exp_sc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rt = 0; ex_memread = 0; branch_taken = 0; jump = 0;
    md_start = 0; md_is_div = 0; id_md_read = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    #2;
    chk("reset_ctrl", 16'(ctrl), 16'h3);
    chk("reset_busy", 16'(md_busy), 16'h0);
    chk("reset_sc", stall_count, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_normal", 16'(ctrl), 16'hC);

    // Load-use on rs: exactly one stall cycle, then EX advances.
    ex_memread = 1; ex_rt = 5'd8; id_rs = 5'd8;
    #1 chk("lu_rs", 16'(ctrl), 16'h1);
    tick(1);
    ex_memread = 0;
    #1 chk("lu_rs_done", 16'(ctrl), 16'hC);
    chk("sc_after_lu", stall_count, 16'd1);

    ex_memread = 1; ex_rt = 5'd0; id_rs = 5'd0;
    #1 chk("lu_r0", 16'(ctrl), 16'hC);
    ex_rt = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 0;
    #1 chk("lu_rt_unused", 16'(ctrl), 16'hC);
    id_uses_rt = 1;
    #1 chk("lu_rt", 16'(ctrl), 16'h1);
    tick(1);
    chk("sc_after_lu_rt", stall_count, 16'd2);

    // Redirects.
    clr();
    branch_taken = 1;
    #1 chk("branch", 16'(ctrl), 16'hA);
    jump = 1;
    #1 chk("branch_jump", 16'(ctrl), 16'hA);
    branch_taken = 0;
    #1 chk("jump", 16'(ctrl), 16'hA);
    tick(0);
    chk("sc_no_stall_redirect", stall_count, 16'd2);
    jump = 0; branch_taken = 1; ex_memread = 1; ex_rt = 5'd8; id_rs = 5'd8;
    #1 chk("branch_lu", 16'(ctrl), 16'h1);
    tick(1);
    clr();
    #1 chk("sc_branch_lu", stall_count, exp_sc);

`ifdef HAZARD_MD_EN
    // Divide occupancy with a HI/LO reader held in ID: 11 stall cycles, 10 busy cycles.
    id_md_read = 1; md_start = 1; md_is_div = 1;
    #1 chk("div_start", 16'(ctrl), 16'h1);
    chk("div_start_busy", 16'(md_busy), 16'h0);
    tick(1);
    md_start = 0; md_is_div = 0;
    for (int i = 0; i < 10; i++) begin
      #1 chk("div_busy", 16'(md_busy), 16'h1);
      chk("div_stall", 16'(ctrl), 16'h1);
      tick(1);
    end
    chk("div_done_busy", 16'(md_busy), 16'h0);
    chk("div_done_ctrl", 16'(ctrl), 16'hC);
    chk("sc_div", stall_count, exp_sc);

    // Restart: multiply, then a divide at count 2 reloads to 10.
    clr();
    md_start = 1;
    tick(0);
    md_start = 0;
    tick(0); tick(0); tick(0);
    chk("mul_busy_at2", 16'(md_busy), 16'h1);
    md_start = 1; md_is_div = 1;
    tick(0);
    md_start = 0; md_is_div = 0;
    for (int i = 0; i < 9; i++) tick(0);
    chk("restart_busy_9", 16'(md_busy), 16'h1);
    tick(0);
    chk("restart_busy_10", 16'(md_busy), 16'h0);
`else
    // Without mult/div tracking those inputs are ignored.
    id_md_read = 1; md_start = 1; md_is_div = 1;
    #1 chk("md_ignored", 16'(ctrl), 16'hC);
    tick(0);
    md_start = 0;
    #1 chk("md_ignored_busy", 16'(md_busy), 16'h0);
    chk("md_ignored_ctrl", 16'(ctrl), 16'hC);
    chk("md_ignored_sc", stall_count, exp_sc);
`endif

    // Saturation.
    clr();
    ex_memread = 1; ex_rt = 5'd8; id_rs = 5'd8;
    for (int i = 0; i < 100; i++) tick(1);
    chk("sc_count_100", stall_count, exp_sc);
    for (int i = 0; i < 70000; i++) tick(1);
    chk("sc_saturated", stall_count, 16'hFFFF);
    tick(1); tick(1); tick(1);
    chk("sc_hold", stall_count, 16'hFFFF);

    // Asynchronous reset mid-divide (count 7 when tracking is present).
    clr();
    md_start = 1; md_is_div = 1;
    tick(0);
    md_start = 0; md_is_div = 0;
    tick(0); tick(0); tick(0);
`ifdef HAZARD_MD_EN
    chk("pre_reset_busy", 16'(md_busy), 16'h1);
`endif
    #3 rst_n = 1'b0;
    #1 chk("mid_reset_ctrl", 16'(ctrl), 16'h3);
    chk("mid_reset_busy", 16'(md_busy), 16'h0);
    chk("mid_reset_sc", stall_count, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_ctrl", 16'(ctrl), 16'hC);
    chk("post_reset_busy", 16'(md_busy), 16'h0);
    chk("post_reset_sc", stall_count, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
